// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches the one-hot phase vector of an upstream 4-bit ring counter. It
//   checks that each sample is legal, tracks the step from one phase to the
//   next, declares lock after LOCK_CNT consecutive +1 advances, and counts
//   completed revolutions while locked.
//
// Ports
//   clk          sole clock, rising edge
//   ORI          synchronous active-high reset (priority over all inputs)
//   ring_in[3:0] one-hot phase vector, bit 0 = phase 0
//   clr_err      synchronous clear of both sticky error flags
//   phase[1:0]   index of the set bit of the last legal sample
//   phase_valid  last sample was exactly one-hot
//   locked       ring is advancing legally
//   rev_pulse    one-cycle pulse per completed revolution (3->0) while locked
//   rev_count    revolutions since lock entry or reset, wraps silently
//   err_onehot   sticky: a non-one-hot sample was seen
//   err_seq      sticky: an illegal phase step was seen while tracking/locked
//
// All outputs are registered and reflect the sample taken at the same edge.
module ring_phase_monitor #(
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             ORI,
  input  logic [3:0]       ring_in,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_count,
  output logic             err_onehot,
  output logic             err_seq
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         adv_cnt_reg, adv_cnt_next;
  logic [1:0]         phase_reg, phase_next;
  logic               phase_valid_reg, phase_valid_next;
  logic               locked_reg, locked_next;
  logic               rev_pulse_reg, rev_pulse_next;
  logic [REV_W-1:0]   rev_count_reg, rev_count_next;
  logic               err_onehot_reg, err_onehot_next;
  logic               err_seq_reg, err_seq_next;

  logic               onehot;
  logic [1:0]         new_idx;
  logic               step_hold;
  logic               step_adv;
  logic               step_skip;

  assign onehot = $onehot(ring_in);

  // Encoder: only meaningful when the sample is one-hot.
  always_comb begin
    new_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (ring_in[i]) begin
        new_idx = 2'(i);
      end
    end
  end

  // Step relative to the last legal phase; 2-bit add wraps 3 -> 0.
  assign step_hold = onehot && (new_idx == phase_reg);
  assign step_adv  = onehot && (new_idx == phase_reg + 2'd1);
  assign step_skip = onehot && !step_hold && !step_adv;

  always_comb begin
    state_next       = state_reg;
    adv_cnt_next     = adv_cnt_reg;
    phase_next       = onehot ? new_idx : phase_reg;
    phase_valid_next = onehot;
    rev_pulse_next   = 1'b0;
    rev_count_next   = rev_count_reg;
    // A fresh error in the same cycle as clr_err wins.
    err_onehot_next  = (err_onehot_reg & ~clr_err) | ~onehot;
    err_seq_next     = err_seq_reg & ~clr_err;

    case (state_reg)
      ACQUIRE: begin
        if (onehot) begin
          state_next   = TRACK;
          adv_cnt_next = 4'd0;
        end
      end
      TRACK: begin
        if (!onehot || step_skip) begin
          state_next   = ACQUIRE;
          adv_cnt_next = 4'd0;
          if (step_skip) begin
            err_seq_next = 1'b1;
          end
        end else if (step_adv) begin
          adv_cnt_next = adv_cnt_reg + 4'd1;
          if (adv_cnt_reg == 4'(LOCK_CNT - 1)) begin
            // Lock entry never pulses, even when this step is 3 -> 0.
            state_next     = LOCKED;
            rev_count_next = '0;
          end
        end
      end
      LOCKED: begin
        if (!onehot || step_skip) begin
          state_next   = ACQUIRE;
          adv_cnt_next = 4'd0;
          if (step_skip) begin
            err_seq_next = 1'b1;
          end
        end else if (step_adv && (phase_reg == 2'd3)) begin
          rev_pulse_next = 1'b1;
          rev_count_next = rev_count_reg + 1'b1;
        end
      end
      default: begin
        state_next   = ACQUIRE;
        adv_cnt_next = 4'd0;
      end
    endcase

    locked_next = (state_next == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (ORI) begin
      state_reg       <= ACQUIRE;
      adv_cnt_reg     <= 4'd0;
      phase_reg       <= 2'd0;
      phase_valid_reg <= 1'b0;
      locked_reg      <= 1'b0;
      rev_pulse_reg   <= 1'b0;
      rev_count_reg   <= '0;
      err_onehot_reg  <= 1'b0;
      err_seq_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      adv_cnt_reg     <= adv_cnt_next;
      phase_reg       <= phase_next;
      phase_valid_reg <= phase_valid_next;
      locked_reg      <= locked_next;
      rev_pulse_reg   <= rev_pulse_next;
      rev_count_reg   <= rev_count_next;
      err_onehot_reg  <= err_onehot_next;
      err_seq_reg     <= err_seq_next;
    end
  end

  assign phase       = phase_reg;
  assign phase_valid = phase_valid_reg;
  assign locked      = locked_reg;
  assign rev_pulse   = rev_pulse_reg;
  assign rev_count   = rev_count_reg;
  assign err_onehot  = err_onehot_reg;
  assign err_seq     = err_seq_reg;

endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 Parameter REV_W, default 8, width of the revolution counter.
REQ-002 Parameter LOCK_CNT, default 4, number of consecutive legal +1 advances needed to declare lock; legal range 1..15.
REQ-003 Block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 ORI  input  1  synchronous active-high reset.
REQ-006 ring_in  input  4  one-hot phase vector from the upstream 4-bit ring counter; bit 0 is phase 0.
REQ-007 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-008 phase  output  2  encoded index of the set bit of the last legal sample.
REQ-009 phase_valid  output  1  last sample was exactly one-hot.
REQ-010 locked  output  1  ring is advancing legally.
REQ-011 rev_pulse  output  1  one-cycle pulse on each completed revolution while locked.
REQ-012 rev_count  output  REV_W  completed revolutions since lock or reset.
REQ-013 err_onehot  output  1  sticky flag for a non-one-hot sample.
REQ-014 err_seq  output  1  sticky flag for an illegal phase step.

Function
REQ-015 Block SHALL sample ring_in on every rising clk edge; all outputs are registered and reflect the sample taken at that same edge (latency 1 cycle).
REQ-016 A sample is one-hot iff exactly one of the 4 bits is 1; 0000 and any multi-bit value are illegal.
REQ-017 On a one-hot sample: phase = index of the set bit, phase_valid = 1; on an illegal sample: phase holds its previous value, phase_valid = 0.
REQ-018 Step classification vs previous legal phase p: new = p -> HOLD; new = (p+1) mod 4 -> ADVANCE; any other value -> SKIP (illegal).
REQ-019 FSM states: ACQUIRE, TRACK, LOCKED.
REQ-020 ACQUIRE: on a one-hot sample record phase, set the advance counter to 0, go to TRACK; otherwise stay.
REQ-021 TRACK: ADVANCE increments the advance counter, and reaching LOCK_CNT goes to LOCKED; HOLD leaves the counter unchanged and stays in TRACK.
REQ-022 LOCKED: ADVANCE or HOLD stays in LOCKED; locked = 1 only in this state.
REQ-023 In TRACK or LOCKED, a non-one-hot sample or SKIP SHALL go to ACQUIRE, clear the advance counter and drop locked in that same cycle.
REQ-024 err_onehot SHALL set on any non-one-hot sample in any state.
REQ-025 err_seq SHALL set on SKIP in TRACK or LOCKED; it is never set from ACQUIRE.
REQ-026 rev_pulse = 1 for exactly one cycle when in LOCKED and an ADVANCE from phase 3 to phase 0 occurs.
REQ-027 rev_count SHALL increment with each rev_pulse, wrap from 2^REV_W-1 to 0 without a flag, and clear on entry to LOCKED.
REQ-028 The transition from TRACK into LOCKED SHALL NOT generate rev_pulse, even on a 3->0 step.
REQ-029 clr_err SHALL clear both sticky flags at the next edge; if a new error occurs in the same cycle, the flag is set (error wins).
REQ-030 clr_err SHALL NOT affect FSM state, phase, or counters.

Reset
REQ-031 With ORI = 1 at a rising edge: state ACQUIRE, phase = 0, phase_valid = 0, locked = 0, rev_pulse = 0, rev_count = 0, err_onehot = 0, err_seq = 0, advance counter = 0.
REQ-032 ORI SHALL take priority over clr_err and over ring_in; ring_in is ignored in any cycle with ORI = 1.
REQ-033 ORI asserted mid-lock SHALL drop locked on the following edge; reacquisition starts from ACQUIRE on the first cycle with ORI = 0.

Verification
REQ-034 Reset, then ring_in 0001,0010,0100,1000,0001 on successive edges (LOCK_CNT = 4) -> locked rises after the 5th sample, rev_count = 0, no rev_pulse.
REQ-035 Continue rotation for 3 full revolutions -> exactly 3 rev_pulse cycles, each coincident with phase 3->0; rev_count = 3.
REQ-036 While locked, drive 0101 for one cycle -> phase_valid = 0, err_onehot = 1, locked = 0, phase holds; a later clr_err with legal input -> err_onehot = 0.
REQ-037 While locked at phase 1, drive 1000 -> err_seq = 1, locked = 0, state ACQUIRE; relock requires 4 further advances.
REQ-038 REV_W = 2, locked, run 5 revolutions -> rev_count sequence 1,2,3,0,1.
REQ-039 clr_err and a SKIP in the same cycle -> err_seq = 1; ORI and clr_err together with ring_in = 0000 -> all flags 0, phase_valid = 0.
